// File: rtl/arith_pkg.sv
// Shared types for the arithmetic core front end: operation codes,
// dispatcher states, unit indices and the op-to-unit one-hot decode.
package arith_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_MULT = 2'b01,
        OP_SQRT = 2'b10,
        OP_NONE = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESPOND
    } state_t;

    localparam int NUM_UNITS = 3;
    localparam int DIV_IDX   = 0;
    localparam int MULT_IDX  = 1;
    localparam int SQRT_IDX  = 2;

    // OP_NONE maps to no unit, so an illegal op can never start or be completed by one.
    function automatic logic [NUM_UNITS-1:0] op_onehot(input op_t op);
        logic [NUM_UNITS-1:0] vec;
        vec = '0;
        case (op)
            OP_DIV:  vec[DIV_IDX]  = 1'b1;
            OP_MULT: vec[MULT_IDX] = 1'b1;
            OP_SQRT: vec[SQRT_IDX] = 1'b1;
            default: vec = '0;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/timeout_counter.sv
// Watchdog counter for the dispatcher WAIT state; expired is high on the
// last allowed wait cycle (count == MAX-1).
module timeout_counter #(
    parameter int MAX = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] count;

    // Saturates at MAX so a stuck enable can never wrap back into range.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != W'(MAX))) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == W'(MAX - 1));

endmodule

// File: rtl/op_dispatcher.sv
// Request sequencer for the divide/multiply/sqrt units: launches one unit,
// waits for its done or a timeout, then captures the muxed result.
module op_dispatcher
    import arith_pkg::*;
#(
    parameter int NBITS   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op_sel,
    input  logic [NBITS-1:0]     operand_a,
    input  logic [NBITS-1:0]     operand_b,
    output logic [NBITS-1:0]     unit_a,
    output logic [NBITS-1:0]     unit_b,
    output logic [NUM_UNITS-1:0] unit_start,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic [1:0]           mux_sel,
    input  logic [NBITS-1:0]     mux_result,
    output logic [NBITS-1:0]     result,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    state_t           state;
    op_t              op_q;
    logic [NBITS-1:0] a_q;
    logic [NBITS-1:0] b_q;
    logic             sel_done;
    logic             expired;
    op_t              req_op;

    assign req_op   = op_t'(op_sel);
    assign sel_done = |(unit_done & op_onehot(op_q));

    assign unit_a  = a_q;
    assign unit_b  = b_q;
    assign mux_sel = op_q;

    timeout_counter #(
        .MAX (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == ST_LAUNCH),
        .enable  (state == ST_WAIT),
        .expired (expired)
    );

    // unit_start, done and error default low each cycle so they can only
    // ever be single-cycle pulses; a captured done takes priority over expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            op_q       <= OP_DIV;
            a_q        <= '0;
            b_q        <= '0;
            unit_start <= '0;
            result     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            unit_start <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q <= req_op;
                        a_q  <= operand_a;
                        b_q  <= operand_b;
                        busy <= 1'b1;
                        if (req_op == OP_NONE) begin
                            result <= '0;
                            done   <= 1'b1;
                            error  <= 1'b1;
                            state  <= ST_RESPOND;
                        end else begin
                            unit_start <= op_onehot(req_op);
                            state      <= ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (sel_done) begin
                        result <= mux_result;
                        done   <= 1'b1;
                        state  <= ST_RESPOND;
                    end else if (expired) begin
                        result <= '0;
                        done   <= 1'b1;
                        error  <= 1'b1;
                        state  <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_op_dispatcher.sv
// Scenario bench for op_dispatcher: the bench plays the arithmetic units and
// a monitor pops expected {result,error} pairs on every done pulse.
module tb_op_dispatcher;

    localparam int NBITS   = 16;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [1:0]       op_sel;
    logic [NBITS-1:0] operand_a;
    logic [NBITS-1:0] operand_b;
    logic [NBITS-1:0] unit_a;
    logic [NBITS-1:0] unit_b;
    logic [2:0]       unit_start;
    logic [2:0]       unit_done;
    logic [1:0]       mux_sel;
    logic [NBITS-1:0] mux_result;
    logic [NBITS-1:0] result;
    logic             busy;
    logic             done;
    logic             error;

    typedef struct packed {
        logic [NBITS-1:0] result;
        logic             error;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    op_dispatcher #(
        .NBITS   (NBITS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start),
        .op_sel     (op_sel),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .unit_start (unit_start),
        .unit_done  (unit_done),
        .mux_sel    (mux_sel),
        .mux_result (mux_result),
        .result     (result),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_done: result=%0d error=%0b with no request outstanding", result, error);
            end else begin
                mon_e = exp_q.pop_front();
                if (result !== mon_e.result || error !== mon_e.error) begin
                    fails++;
                    $display("[TB] FAIL response: result=%0d error=%0b expected result=%0d error=%0b",
                             result, error, mon_e.result, mon_e.error);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Called in IDLE at a negedge (cycle 0); returns at the negedge of cycle 1.
    task automatic issue(input logic [1:0] op, input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
        start     = 1'b1;
        op_sel    = op;
        operand_a = a;
        operand_b = b;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        start      = 1'b0;
        op_sel     = 2'b00;
        operand_a  = '0;
        operand_b  = '0;
        unit_done  = '0;
        mux_result = '0;
        step(2);
        checks++;
        if ({unit_a, unit_b, unit_start, mux_sel, result, busy, done, error} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: a=%0d b=%0d start=%b sel=%b res=%0d busy=%b done=%b err=%b expected all 0",
                     unit_a, unit_b, unit_start, mux_sel, result, busy, done, error);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || unit_start !== 3'b000) begin
            fails++;
            $display("[TB] FAIL idle_after_reset: busy=%b unit_start=%b expected 0 000", busy, unit_start);
        end
    endtask

    task automatic test_reset_mid_wait;
        issue(2'b01, 16'd3, 16'd4);
        step(2);
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_wait_busy: busy=%b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({unit_a, unit_b, unit_start, mux_sel, result, busy, done, error} !== '0) begin
            fails++;
            $display("[TB] FAIL async_reset: a=%0d b=%0d start=%b sel=%b res=%0d busy=%b done=%b err=%b expected all 0",
                     unit_a, unit_b, unit_start, mux_sel, result, busy, done, error);
        end
        step(2);
        rst_n = 1'b1;
        step();
        exp_q.push_back('{result: 16'd14, error: 1'b0});
        issue(2'b00, 16'd100, 16'd7);
        checks++;
        if (unit_start !== 3'b001 || unit_a !== 16'd100 || unit_b !== 16'd7) begin
            fails++;
            $display("[TB] FAIL div_launch: unit_start=%b a=%0d b=%0d expected 001 100 7", unit_start, unit_a, unit_b);
        end
        step(4);
        checks++;
        if (done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL div_early_done: done=%b expected 0 in cycle 5", done);
        end
        unit_done  = 3'b001;
        mux_result = 16'd14;
        step();
        unit_done  = '0;
        mux_result = '0;
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || result !== 16'd14) begin
            fails++;
            $display("[TB] FAIL div_done_cycle6: done=%b error=%b result=%0d expected 1 0 14", done, error, result);
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL div_back_idle: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_mult_wrong_done;
        exp_q.push_back('{result: 16'd132, error: 1'b0});
        issue(2'b01, 16'd12, 16'd11);
        checks++;
        if (unit_start !== 3'b010 || mux_sel !== 2'b01) begin
            fails++;
            $display("[TB] FAIL mult_launch: unit_start=%b mux_sel=%b expected 010 01", unit_start, mux_sel);
        end
        step();
        unit_done  = 3'b001;
        mux_result = 16'd999;
        step();
        unit_done  = '0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mult_wrong_done: done=%b busy=%b expected 0 1", done, busy);
        end
        unit_done  = 3'b010;
        mux_result = 16'd132;
        step();
        unit_done  = '0;
        mux_result = '0;
        checks++;
        if (done !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mult_done: done=%b expected 1", done);
        end
        step();
    endtask

    task automatic test_timeout;
        exp_q.push_back('{result: 16'd0, error: 1'b1});
        issue(2'b00, 16'd50, 16'd5);
        for (int c = 1; c <= TIMEOUT + 2; c++) begin
            checks++;
            if (done !== (c == TIMEOUT + 2)) begin
                fails++;
                $display("[TB] FAIL timeout_cycle%0d: done=%b expected %b", c, done, (c == TIMEOUT + 2));
            end
            if (c < TIMEOUT + 2) step();
        end
        checks++;
        if (error !== 1'b1 || result !== 16'd0 || mux_sel !== 2'b00) begin
            fails++;
            $display("[TB] FAIL timeout_error: error=%b result=%0d mux_sel=%b expected 1 0 00", error, result, mux_sel);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL timeout_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_sqrt_early_done;
        exp_q.push_back('{result: 16'd12, error: 1'b0});
        issue(2'b10, 16'd144, 16'd0);
        unit_done  = 3'b100;
        mux_result = 16'd77;
        checks++;
        if (unit_start !== 3'b100 || mux_sel !== 2'b10) begin
            fails++;
            $display("[TB] FAIL sqrt_launch: unit_start=%b mux_sel=%b expected 100 10", unit_start, mux_sel);
        end
        step();
        unit_done  = '0;
        mux_result = '0;
        checks++;
        if (done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL sqrt_launch_done_ignored: done=%b expected 0", done);
        end
        step();
        unit_done  = 3'b100;
        mux_result = 16'd12;
        step();
        unit_done  = '0;
        mux_result = '0;
        checks++;
        if (done !== 1'b1 || result !== 16'd12) begin
            fails++;
            $display("[TB] FAIL sqrt_done: done=%b result=%0d expected 1 12", done, result);
        end
        step();
    endtask

    task automatic test_illegal;
        exp_q.push_back('{result: 16'd0, error: 1'b1});
        issue(2'b11, 16'd5, 16'd6);
        checks++;
        if (unit_start !== 3'b000 || done !== 1'b1 || error !== 1'b1 || result !== 16'd0 || busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL illegal_cycle1: start=%b done=%b err=%b res=%0d busy=%b expected 000 1 1 0 1",
                     unit_start, done, error, result, busy);
        end
        step();
        checks++;
        if (busy !== 1'b0 || unit_start !== 3'b000 || done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL illegal_cycle2: busy=%b start=%b done=%b expected 0 000 0", busy, unit_start, done);
        end
    endtask

    task automatic test_start_while_busy;
        int pulses;
        pulses = 0;
        exp_q.push_back('{result: 16'd15, error: 1'b0});
        issue(2'b01, 16'd3, 16'd5);
        for (int c = 1; c <= 10; c++) begin
            if (unit_start !== 3'b000) pulses++;
            start      = (c == 2 || c == 4);
            op_sel     = 2'b00;
            operand_a  = 16'd999;
            unit_done  = (c == 6) ? 3'b010 : 3'b000;
            mux_result = (c == 6) ? 16'd15 : 16'd0;
            step();
        end
        checks++;
        if (pulses != 1 || unit_a !== 16'd3 || mux_sel !== 2'b01) begin
            fails++;
            $display("[TB] FAIL busy_starts_ignored: pulses=%0d unit_a=%0d mux_sel=%b expected 1 3 01", pulses, unit_a, mux_sel);
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL busy_starts_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        exp_q.push_back('{result: 16'd18, error: 1'b0});
        exp_q.push_back('{result: 16'd18, error: 1'b0});
        start     = 1'b1;
        op_sel    = 2'b01;
        operand_a = 16'd2;
        operand_b = 16'd9;
        step();
        checks++;
        if (unit_start !== 3'b010) begin
            fails++;
            $display("[TB] FAIL held_first_launch: unit_start=%b expected 010", unit_start);
        end
        step();
        unit_done  = 3'b010;
        mux_result = 16'd18;
        step();
        unit_done  = '0;
        mux_result = '0;
        checks++;
        if (done !== 1'b1) begin
            fails++;
            $display("[TB] FAIL held_first_done: done=%b expected 1", done);
        end
        step();
        checks++;
        if (busy !== 1'b0 || unit_start !== 3'b000) begin
            fails++;
            $display("[TB] FAIL held_idle_gap: busy=%b unit_start=%b expected 0 000", busy, unit_start);
        end
        step();
        start = 1'b0;
        checks++;
        if (unit_start !== 3'b010) begin
            fails++;
            $display("[TB] FAIL held_relaunch: unit_start=%b expected 010", unit_start);
        end
        step();
        unit_done  = 3'b010;
        mux_result = 16'd18;
        step();
        unit_done  = '0;
        mux_result = '0;
        checks++;
        if (done !== 1'b1) begin
            fails++;
            $display("[TB] FAIL held_second_done: done=%b expected 1", done);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_reset_mid_wait();
        test_mult_wrong_done();
        test_timeout();
        test_sqrt_early_done();
        test_illegal();
        test_start_while_busy();
        test_back_to_back();
        step(3);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
